// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly in front of the instruction register. It owns
// the program counter, issues word fetches over a req/gnt/rvalid handshake,
// keeps returned words (tagged with their PC) in a small in-order queue and
// hands them to the instruction register with a valid/ready handshake.
// Redirects (branch/jump/trap) reload the PC, flush the queue and discard any
// responses that are still in flight.
//
// Parameters
//   RESET_PC  first PC fetched after reset
//   DEPTH     fetch queue entries; also the bound on
//             (buffered words + outstanding requests)
//
// Ports
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   redirect_i        load redirect_pc_i into the PC and flush the queue
//   redirect_pc_i     redirect target
//   imem_req_o        fetch request
//   imem_addr_o       fetch address (current PC)
//   imem_gnt_i        memory accepted the request this cycle
//   imem_rvalid_i     response word valid
//   imem_rdata_i      response word
//   instr_valid_o     instr_o / instr_pc_o valid
//   instr_o           fetched instruction (instruction register D input)
//   instr_pc_o        PC of instr_o
//   instr_ready_i     consumer accepts instr_o this cycle
//   fetch_misalign_o  (FETCH_MISALIGN_EN only) a misaligned redirect target
//                     is held in the PC; fetching is stalled until the next
//                     aligned redirect
//
// Build option
//   FETCH_MISALIGN_EN  when defined, misaligned redirect targets are flagged
//                      on fetch_misalign_o instead of being silently aligned.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state;
  logic               live;          // low until the first edge after reset
  logic [31:0]        pc;
  logic [CNT_W-1:0]   outstanding;   // granted requests awaiting a response
  logic [CNT_W-1:0]   discard;       // oldest outstanding responses to drop
  logic [CNT_W-1:0]   count;         // words held in the fetch queue
  logic               misalign;

  // Fetch queue, entry 0 is the head and drives the outputs directly.
  logic [31:0]        q_instr [DEPTH];
  logic [31:0]        q_pc    [DEPTH];
  // PCs of granted requests, in grant order, entry 0 is the oldest.
  logic [31:0]        pend_pc [DEPTH];

  logic [CNT_W:0]     occupancy;
  logic               gnt_fire;
  logic               rsp;
  logic               rsp_keep;
  logic               rsp_drop;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   outstanding_nxt;
  logic [CNT_W-1:0]   discard_dec;
  logic [CNT_W-1:0]   q_wr;
  logic [CNT_W-1:0]   pend_wr;
  logic [31:0]        target_pc;
  logic               target_misalign;

  // ---- request / response bookkeeping ------------------------------------
  assign occupancy  = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_o = live && (state == RUN) && (occupancy < DEPTH_W) && !misalign;
  assign imem_addr_o = pc;

  assign gnt_fire = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding (e.g. one issued before a reset) is ignored.
  assign rsp      = imem_rvalid_i && (outstanding != '0);
  assign rsp_keep = rsp && (discard == '0);
  assign rsp_drop = rsp && (discard != '0);

  // A redirect flushes the queue, so the head is dropped and the incoming word too.
  assign push = rsp_keep && !redirect_i;
  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

  assign outstanding_nxt = outstanding + CNT_W'(gnt_fire) - CNT_W'(rsp);
  assign discard_dec     = discard - CNT_W'(rsp_drop);

  assign q_wr    = pop ? (count - 1'b1) : count;
  assign pend_wr = rsp ? (outstanding - 1'b1) : outstanding;

`ifdef FETCH_MISALIGN_EN
  assign target_pc        = redirect_pc_i;
  assign target_misalign  = |redirect_pc_i[1:0];
  assign fetch_misalign_o = misalign;
`else
  assign target_pc        = redirect_pc_i & ~32'h0000_0003;
  assign target_misalign  = 1'b0;
`endif

  // ---- control state: PC, counters, FSM ----------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      live        <= 1'b0;
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      misalign    <= 1'b0;
    end else begin
      live        <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        pc       <= target_pc;
        misalign <= target_misalign;
        count    <= '0;
        // Everything still in flight after this cycle belongs to the old stream.
        discard  <= outstanding_nxt;
        state    <= (outstanding_nxt != '0) ? DRAIN : RUN;
      end else begin
        if (gnt_fire) begin
          pc <= pc + 32'd4;
        end
        discard <= discard_dec;
        count   <= count + CNT_W'(push) - CNT_W'(pop);
        if ((state == DRAIN) && (discard_dec == '0)) begin
          state <= RUN;
        end
      end
    end
  end

  // ---- fetch queue -------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          q_instr[i] <= q_instr[i+1];
          q_pc[i]    <= q_pc[i+1];
        end
      end
      // Placed after the shift so a same-cycle push lands in the freed slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (q_wr == CNT_W'(i))) begin
          q_instr[i] <= imem_rdata_i;
          q_pc[i]    <= pend_pc[0];
        end
      end
    end
  end

  assign instr_valid_o = (count != '0);
  assign instr_o       = q_instr[0];
  assign instr_pc_o    = q_pc[0];

  // ---- pending-PC queue --------------------------------------------------
  // Popped on every accepted response, kept or dropped, so its length always
  // equals outstanding and its head is the PC of the next response.
  always_ff @(posedge clk) begin
    if (rsp) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        pend_pc[i] <= pend_pc[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt_fire && (pend_wr == CNT_W'(i))) begin
        pend_pc[i] <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: per-cycle directed vectors followed by
// hand-written sequences for wrap, redirect-with-grant, redirect in DRAIN,
// misaligned targets and reset in mid-operation.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign_o;
`endif

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misalign_o (fetch_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc,
                              input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vld, input logic [31:0] e_instr,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.redir = redir;  v.rpc = rpc;   v.gnt = gnt; v.rv = rv;
    v.rdata = rdata;  v.rdy = rdy;
    v.e_req = e_req;  v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_instr = e_instr; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the outputs mid-cycle, advance one clock.
  task automatic apply(input vec_t v, input string tag);
    redirect_i    = v.redir;
    redirect_pc_i = v.rpc;
    imem_gnt_i    = v.gnt;
    imem_rvalid_i = v.rv;
    imem_rdata_i  = v.rdata;
    instr_ready_i = v.rdy;
    @(negedge clk);
    chk({tag, ".req"},   {31'd0, imem_req_o},    {31'd0, v.e_req});
    chk({tag, ".addr"},  imem_addr_o,            v.e_addr);
    chk({tag, ".valid"}, {31'd0, instr_valid_o}, {31'd0, v.e_vld});
    if (v.e_vld) begin
      chk({tag, ".instr"}, instr_o,    v.e_instr);
      chk({tag, ".ipc"},   instr_pc_o, v.e_ipc);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [27];
  logic [31:0] resume_pc;

  initial begin
    //             redir rpc            gnt rv rdata          rdy | req addr          vld instr          ipc
    tbl[0]  = mk(0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h0000_0000, 0, 32'h0,         32'h0);
    tbl[1]  = mk(0, 32'h0,         1, 1, 32'h0000_0032, 1,  1, 32'h0000_0004, 0, 32'h0,         32'h0);
    tbl[2]  = mk(0, 32'h0,         1, 1, 32'h0000_0036, 1,  0, 32'h0000_0008, 1, 32'h0000_0032, 32'h0000_0000);
    tbl[3]  = mk(0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h0000_0008, 1, 32'h0000_0036, 32'h0000_0004);
    tbl[4]  = mk(0, 32'h0,         1, 1, 32'h0000_003A, 1,  1, 32'h0000_000C, 0, 32'h0,         32'h0);
    tbl[5]  = mk(0, 32'h0,         1, 1, 32'h0000_003E, 0,  0, 32'h0000_0010, 1, 32'h0000_003A, 32'h0000_0008);
    tbl[6]  = mk(0, 32'h0,         1, 0, 32'h0,         0,  0, 32'h0000_0010, 1, 32'h0000_003A, 32'h0000_0008);
    tbl[7]  = mk(0, 32'h0,         1, 0, 32'h0,         0,  0, 32'h0000_0010, 1, 32'h0000_003A, 32'h0000_0008);
    tbl[8]  = mk(0, 32'h0,         1, 0, 32'h0,         0,  0, 32'h0000_0010, 1, 32'h0000_003A, 32'h0000_0008);
    tbl[9]  = mk(0, 32'h0,         1, 0, 32'h0,         0,  0, 32'h0000_0010, 1, 32'h0000_003A, 32'h0000_0008);
    tbl[10] = mk(0, 32'h0,         1, 0, 32'h0,         1,  0, 32'h0000_0010, 1, 32'h0000_003A, 32'h0000_0008);
    tbl[11] = mk(0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h0000_0010, 1, 32'h0000_003E, 32'h0000_000C);
    tbl[12] = mk(0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h0000_0010, 0, 32'h0,         32'h0);
    tbl[13] = mk(0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h0000_0010, 0, 32'h0,         32'h0);
    tbl[14] = mk(0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h0000_0010, 0, 32'h0,         32'h0);
    tbl[15] = mk(0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h0000_0014, 0, 32'h0,         32'h0);
    tbl[16] = mk(1, 32'h0000_0100, 0, 0, 32'h0,         1,  0, 32'h0000_0018, 0, 32'h0,         32'h0);
    tbl[17] = mk(0, 32'h0,         1, 1, 32'hDEAD_0010, 1,  0, 32'h0000_0100, 0, 32'h0,         32'h0);
    tbl[18] = mk(0, 32'h0,         1, 1, 32'hDEAD_0014, 1,  0, 32'h0000_0100, 0, 32'h0,         32'h0);
    tbl[19] = mk(0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h0000_0100, 0, 32'h0,         32'h0);
    tbl[20] = mk(0, 32'h0,         0, 1, 32'h1111_0100, 0,  1, 32'h0000_0104, 0, 32'h0,         32'h0);
    tbl[21] = mk(0, 32'h0,         1, 0, 32'h0,         0,  1, 32'h0000_0104, 1, 32'h1111_0100, 32'h0000_0100);
    tbl[22] = mk(1, 32'h0000_0200, 1, 1, 32'h2222_0104, 1,  0, 32'h0000_0108, 1, 32'h1111_0100, 32'h0000_0100);
    tbl[23] = mk(0, 32'h0,         1, 0, 32'h0,         1,  1, 32'h0000_0200, 0, 32'h0,         32'h0);
    tbl[24] = mk(0, 32'h0,         0, 1, 32'h3333_0200, 1,  1, 32'h0000_0204, 0, 32'h0,         32'h0);
    tbl[25] = mk(0, 32'h0,         0, 0, 32'h0,         1,  1, 32'h0000_0204, 1, 32'h3333_0200, 32'h0000_0200);
    tbl[26] = mk(0, 32'h0,         0, 0, 32'h0,         0,  1, 32'h0000_0204, 0, 32'h0,         32'h0);

    redirect_i = 0; redirect_pc_i = '0; imem_gnt_i = 0; imem_rvalid_i = 0;
    imem_rdata_i = '0; instr_ready_i = 0;

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.req",   {31'd0, imem_req_o},    32'd0);
    chk("rst.valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst.instr", instr_o,                32'd0);
    chk("rst.ipc",   instr_pc_o,             32'd0);
    chk("rst.addr",  imem_addr_o,            32'd0);
`ifdef FETCH_MISALIGN_EN
    chk("rst.misalign", {31'd0, fetch_misalign_o}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // PC wrap from 0xFFFF_FFFC to 0
    apply(mk(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0,  1, 32'h0000_0204, 0, 32'h0, 32'h0), "wrap0");
    apply(mk(0, 32'h0,         1, 0, 32'h0, 0,  1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0), "wrap1");
    apply(mk(0, 32'h0,         0, 1, 32'hAAAA_5555, 0,  1, 32'h0000_0000, 0, 32'h0, 32'h0), "wrap2");
    apply(mk(0, 32'h0,         0, 0, 32'h0, 1,  1, 32'h0000_0000, 1, 32'hAAAA_5555, 32'hFFFF_FFFC), "wrap3");

    // Redirect together with a grant, then a second redirect while draining
    apply(mk(1, 32'h0000_0400, 1, 0, 32'h0, 0,  1, 32'h0000_0000, 0, 32'h0, 32'h0), "rgnt0");
    apply(mk(1, 32'h0000_0500, 1, 0, 32'h0, 0,  0, 32'h0000_0400, 0, 32'h0, 32'h0), "rdrn0");
    apply(mk(0, 32'h0,         1, 1, 32'hBAD0_0000, 1,  0, 32'h0000_0500, 0, 32'h0, 32'h0), "rdrn1");
    apply(mk(0, 32'h0,         0, 0, 32'h0, 0,  1, 32'h0000_0500, 0, 32'h0, 32'h0), "rdrn2");

    // Misaligned redirect target
    apply(mk(1, 32'h0000_0603, 0, 0, 32'h0, 0,  1, 32'h0000_0500, 0, 32'h0, 32'h0), "mis0");
`ifdef FETCH_MISALIGN_EN
    chk("mis0.flag_pre", {31'd0, fetch_misalign_o}, 32'd1);
    apply(mk(1, 32'h0000_0200, 1, 0, 32'h0, 0,  0, 32'h0000_0603, 0, 32'h0, 32'h0), "mis1");
    chk("mis1.flag", {31'd0, fetch_misalign_o}, 32'd0);
    apply(mk(0, 32'h0,         0, 0, 32'h0, 0,  1, 32'h0000_0200, 0, 32'h0, 32'h0), "mis2");
    resume_pc = 32'h0000_0200;
`else
    apply(mk(0, 32'h0,         0, 0, 32'h0, 0,  1, 32'h0000_0600, 0, 32'h0, 32'h0), "mis1");
    resume_pc = 32'h0000_0600;
`endif

    // Reset with a word buffered, then a stray response afterwards
    apply(mk(0, 32'h0, 1, 0, 32'h0,         0,  1, resume_pc,         0, 32'h0, 32'h0), "mrst0");
    apply(mk(0, 32'h0, 0, 1, 32'h1234_5678, 0,  1, resume_pc + 32'd4, 0, 32'h0, 32'h0), "mrst1");
    imem_gnt_i = 1'b1;
    apply(mk(0, 32'h0, 1, 0, 32'h0,         0,  1, resume_pc + 32'd4, 1, 32'h1234_5678, resume_pc), "mrst2");
    rst_n = 1'b0;
    #1;
    chk("mrst.req",   {31'd0, imem_req_o},    32'd0);
    chk("mrst.valid", {31'd0, instr_valid_o}, 32'd0);
    chk("mrst.instr", instr_o,                32'd0);
    chk("mrst.ipc",   instr_pc_o,             32'd0);
    chk("mrst.addr",  imem_addr_o,            32'd0);
    imem_gnt_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(0, 32'h0, 0, 1, 32'hFEED_FEED, 1,  1, 32'h0000_0000, 0, 32'h0, 32'h0), "stray0");
    apply(mk(0, 32'h0, 0, 0, 32'h0,         1,  1, 32'h0000_0000, 0, 32'h0, 32'h0), "stray1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
